multiplier_unit: RTL and testbench

- Iterative shift-add multiplier that executes the `mult` and `multu` instructions and owns the HI/LO product registers.
- Sits in the execute stage, downstream of the decode-stage control unit; consumes its `multstart` and `multsgn` flags once they have been piped into E.
- `busy` feeds the hazard unit so that dependent `mfhi`/`mflo` and new multiplies are stalled.
- `hi`/`lo` feed the writeback mux as the product-register sources.

---
 rtl/multiplier_unit.sv | 177 +++++++++++++++++
 tb/tb_multiplier_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_unit.sv
// -----------------------------------------------------------------------------
// multiplier_unit
//
// Iterative shift-add multiplier for the execute stage. It runs the mult
// (signed) and multu (unsigned) instructions and owns the HI/LO product
// registers that mfhi/mflo read through the writeback mux.
//
// Signed operands are converted to magnitudes on start. The unsigned
// magnitudes are multiplied one multiplier bit per cycle, and the product is
// negated at the end when exactly one operand was negative.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; forces IDLE and clears hi/lo/done
//   multstartE  start request, only looked at while idle
//   multsgnE    1 = signed (mult), 0 = unsigned (multu); sampled with start
//   srcaE       multiplicand, sampled with start
//   srcbE       multiplier, sampled with start
//   hi, lo      upper/lower halves of the 2*WIDTH-bit product register
//   busy        high whenever an operation is in flight (hazard unit stall)
//   done        one-cycle pulse in the first cycle the new hi/lo are visible
//
// Parameters:
//   WIDTH       operand width; the product is 2*WIDTH bits
//
// Build option:
//   MULT_EARLY_TERM_EN  when defined, a RUN cycle that finds the remaining
//                       multiplier bits all zero jumps straight to FINISH.
//                       Latency then depends on the data. Results are
//                       identical with or without the option.
// -----------------------------------------------------------------------------
module multiplier_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multstartE,
  input  logic             multsgnE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        ONE_C      = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_P      = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } stateT;

  stateT              state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               sgnR;
  logic               negR;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] accSum;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes for the start cycle. A negative operand is only
  // negated for signed multiplies. The most negative value negates to itself,
  // which is already its correct magnitude when read as unsigned.
  always_comb begin
    magA = srcaE;
    magB = srcbE;
    if (multsgnE && srcaE[WIDTH-1]) begin
      magA = ~srcaE + ONE_W;
    end
    if (multsgnE && srcbE[WIDTH-1]) begin
      magB = ~srcbE + ONE_W;
    end
  end

  // Per-cycle partial product and the final sign fix-up. negR can only be
  // set for signed operations. Gating it with sgnR makes it explicit that an
  // unsigned product is never negated.
  always_comb begin
    accSum = acc;
    if (mplier[0]) begin
      accSum = acc + mcand;
    end
    result = acc;
    if (sgnR && negR) begin
      result = ~acc + ONE_P;
    end
  end

  // The hazard unit needs busy during the same cycle the state changes, so
  // busy is decoded directly from the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Control FSM and datapath registers. hi/lo are written only on the
  // FINISH edge, so they keep the previous product for the whole operation.
  // done is a registered pulse that lands in the first IDLE cycle after
  // FINISH, which means it never overlaps busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sgnR   <= 1'b0;
      negR   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (multstartE) begin
            sgnR   <= multsgnE;
            negR   <= multsgnE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, magA};
            mplier <= magB;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
`ifdef MULT_EARLY_TERM_EN
          // No multiplier bits are left, so the accumulator already holds
          // the full magnitude product.
          if (mplier == '0) begin
            state <= FINISH;
          end else begin
            acc    <= accSum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + ONE_C;
            if (count == LAST_COUNT) begin
              state <= FINISH;
            end
          end
`else
          acc    <= accSum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + ONE_C;
          if (count == LAST_COUNT) begin
            state <= FINISH;
          end
`endif
        end

        FINISH: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_unit.sv
// -----------------------------------------------------------------------------
// tb_multiplier_unit
//
// Directed testbench for multiplier_unit. A table of hand-computed products
// runs back to back: each operation starts in the done cycle of the previous
// one. Hand-written sequences then cover the ignored-start case and a reset
// in the middle of RUN.
// -----------------------------------------------------------------------------
module tb_multiplier_unit;

  localparam int W       = 32;
  localparam int TIMEOUT = 200;

  logic         clk;
  logic         reset;
  logic         multstartE;
  logic         multsgnE;
  logic [W-1:0] srcaE;
  logic [W-1:0] srcbE;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int assertCount;
  int failCount;

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vecT;

  vecT vecs[$];

  multiplier_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .multstartE (multstartE),
    .multsgnE   (multsgnE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and keep score.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Expected number of cycles from the start cycle to the done cycle. The
  // start cycle counts as 0. One cycle is the start edge, then the RUN
  // cycles, then the FINISH edge.
  function automatic int expLatency(input logic s, input logic [W-1:0] b);
    int runs;
    runs = W;
`ifdef MULT_EARLY_TERM_EN
    begin
      logic [W-1:0] m;
      int hb;
      m  = (s && b[W-1]) ? (~b + 32'd1) : b;
      hb = -1;
      for (int i = 0; i < W; i++) begin
        if (m[i]) hb = i;
      end
      if (hb < 0) runs = 1;
      else        runs = (hb + 2 > W) ? W : hb + 2;
    end
`else
    if (s === 1'bx && b === '0) runs = W;
`endif
    return runs + 2;
  endfunction

  // Issue one multiply from the current cycle, which must sit 1 time unit
  // after an edge. The task returns in the done cycle and reports how many
  // cycles that took. It also reports whether busy rose after the start edge
  // and whether hi/lo held steady and done stayed low while busy was high.
  task automatic applyStimulus(input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, output int cyc,
                               output logic acceptOk, output logic holdOk);
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    h0         = hi;
    l0         = lo;
    holdOk     = 1'b1;
    multstartE = 1'b1;
    multsgnE   = s;
    srcaE      = a;
    srcbE      = b;
    @(posedge clk); #1;
    cyc        = 1;
    acceptOk   = busy;
    // Scramble the operands after the start edge because the unit must not
    // look at them again.
    multstartE = 1'b0;
    multsgnE   = ~s;
    srcaE      = $urandom;
    srcbE      = $urandom;
    while (!done && cyc < TIMEOUT) begin
      if (hi !== h0 || lo !== l0 || (busy && done)) holdOk = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int           cyc;
    logic         acceptOk;
    logic         holdOk;
    logic         sawDone;
    logic         sawBusy;
    logic [W-1:0] h0;
    logic [W-1:0] l0;

    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    multstartE  = 1'b0;
    multsgnE    = 1'b0;
    srcaE       = '0;
    srcbE       = '0;

    vecs.push_back('{"umax",       1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"sMixed",     1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"uMixed",     1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1});
    vecs.push_back('{"sMinMin",    1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"uMinMin",    1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"sNeg1Neg1",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    vecs.push_back('{"sMaxMax",    1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001});
    vecs.push_back('{"sMinTimes1", 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"u2pow32",    1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vecs.push_back('{"uTimes1",    1'b0, 32'h12345678, 32'h00000001, 32'h00000000, 32'h12345678});
    vecs.push_back('{"sNegTimes0", 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000});
    vecs.push_back('{"u5Times0",   1'b0, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000});
    vecs.push_back('{"sPosNeg",    1'b1, 32'h00001234, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFDB98});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetHi",   64'(hi),   64'h0);
    checkOutput("resetLo",   64'(lo),   64'h0);
    checkOutput("resetBusy", 64'(busy), 64'h0);
    checkOutput("resetDone", 64'(done), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors. Each start lands in the previous done cycle.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, cyc, acceptOk, holdOk);
      checkOutput({vecs[i].name, "_result"}, {hi, lo}, {vecs[i].expHi, vecs[i].expLo});
      checkOutput({vecs[i].name, "_latency"}, 64'(cyc),
                  64'(expLatency(vecs[i].sgn, vecs[i].b)));
      checkOutput({vecs[i].name, "_accept"}, 64'(acceptOk), 64'h1);
      checkOutput({vecs[i].name, "_hold"}, 64'(holdOk), 64'h1);
      checkOutput({vecs[i].name, "_busyInDone"}, 64'(busy), 64'h0);
    end

    // A start pulsed 10 cycles into a running op must be ignored.
    h0         = hi;
    l0         = lo;
    holdOk     = 1'b1;
    multstartE = 1'b1;
    multsgnE   = 1'b0;
    srcaE      = 32'd7;
    srcbE      = 32'd6;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < TIMEOUT) begin
      if (cyc == 10) begin
        multstartE = 1'b1;
        srcaE      = 32'd2;
        srcbE      = 32'd2;
      end else begin
        multstartE = 1'b0;
      end
      if (hi !== h0 || lo !== l0) holdOk = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    multstartE = 1'b0;
    checkOutput("ignoreStart_result",  {hi, lo}, {32'd0, 32'd42});
    checkOutput("ignoreStart_latency", 64'(cyc), 64'(expLatency(1'b0, 32'd6)));
    checkOutput("ignoreStart_hold",    64'(holdOk), 64'h1);
    @(posedge clk); #1;
    checkOutput("ignoreStart_noRestart", 64'(busy), 64'h0);

    // Reset during RUN. hi/lo currently hold 42, so clearing them is visible.
    multstartE = 1'b1;
    multsgnE   = 1'b0;
    srcaE      = 32'hFFFFFFFF;
    srcbE      = 32'hFFFFFFFF;
    @(posedge clk); #1;
    multstartE = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checkOutput("midRun_busyBefore", 64'(busy), 64'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midReset_busy", 64'(busy), 64'h0);
    checkOutput("midReset_hilo", {hi, lo}, 64'h0);
    sawDone = 1'b0;
    sawBusy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) sawDone = 1'b1;
      if (busy) sawBusy = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("midReset_noDone", 64'(sawDone), 64'h0);
    checkOutput("midReset_staysIdle", 64'(sawBusy), 64'h0);

    // A normal operation after the aborted one.
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'h00000006, cyc, acceptOk, holdOk);
    checkOutput("afterReset_result",  {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFD6});
    checkOutput("afterReset_latency", 64'(cyc), 64'(expLatency(1'b1, 32'h00000006)));
    checkOutput("afterReset_accept",  64'(acceptOk), 64'h1);
    checkOutput("afterReset_hold",    64'(holdOk), 64'h1);
    @(posedge clk); #1;
    checkOutput("afterReset_donePulse", 64'(done), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
